// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: instruction/opcode geometry and fetch FSM states.
package legv8_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 11;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;

  // All-zero opcode makes the control unit drive every control line low.
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 11'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  // Extract the 11-bit primary opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register. Captures a fetched instruction that
// arrived while decode was stalled so it can be replayed into IF/ID later.
// Clear wins over load so a redirect always drops the held entry.
module fetch_skid_buffer
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Entry register: clear has priority, load captures the pc/instr pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 instruction fetch stage with IF/ID pipeline register.
// Holds the PC, requests words from instruction memory, absorbs one response
// during a decode stall via a skid buffer, and flushes IF/ID on branch redirect.
//
// Memory handshake: imem_req is the request valid and imem_addr the payload;
// a word transfers on a rising edge where imem_req=1 and imem_ready=1, with
// imem_rdata valid in that same cycle. While imem_req=1 and imem_ready=0 the
// address is held stable; only a branch redirect may change it.
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ready,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                if_id_valid,
  output logic [ADDR_W-1:0]   if_id_pc,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [OPCODE_W-1:0] operation,
  output fetch_state_e        dbg_state
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;

  logic               r_if_id_valid;
  logic [ADDR_W-1:0]  r_if_id_pc;
  logic [INSTR_W-1:0] r_if_id_instr;

  logic               w_in_fetch;
  logic               w_in_full;
  logic               w_resp;
  logic               w_take_direct;
  logic               w_take_skid;
  logic               w_bubble;
  logic               w_release;
  logic               w_skid_clear;
  logic [ADDR_W-1:0]  w_redirect_pc;

  logic               w_skid_valid;
  logic [ADDR_W-1:0]  w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;

  // Decode of the current state and the events that move data this cycle.
  always_comb begin
    w_in_fetch    = (r_state == FETCH);
    w_in_full     = (r_state == FULL);
    w_resp        = w_in_fetch && imem_ready && !branch_taken;
    w_take_direct = w_resp && !stall;
    w_take_skid   = w_resp && stall;
    w_bubble      = w_in_fetch && !imem_ready && !stall && !branch_taken;
    w_release     = w_in_full && !stall && !branch_taken;
    w_skid_clear  = branch_taken || w_release;
    w_redirect_pc = branch_target & ALIGN_MASK;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; a redirect always lands in FETCH.
  always_comb begin
    w_state_nxt = r_state;
    if (branch_taken) begin
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = FETCH;
        FETCH:   if (imem_ready && stall) w_state_nxt = FULL;
        FULL:    if (!stall) w_state_nxt = FETCH;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: requests are only issued from FETCH, always at the PC.
  always_comb begin
    imem_req  = w_in_fetch;
    imem_addr = r_pc;
    dbg_state = r_state;
  end

  // Program counter: redirect, advance on every accepted word, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_pc <= RESET_PC;
    else if (branch_taken) r_pc <= w_redirect_pc;
    else if (w_resp)       r_pc <= r_pc + PC_STEP;
  end

  // IF/ID register: flush on redirect, load direct or from skid, bubble on miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else if (branch_taken) begin
      r_if_id_valid <= 1'b0;
    end else if (w_take_direct) begin
      r_if_id_valid <= 1'b1;
      r_if_id_pc    <= r_pc;
      r_if_id_instr <= imem_rdata;
    end else if (w_release) begin
      r_if_id_valid <= w_skid_valid;
      r_if_id_pc    <= w_skid_pc;
      r_if_id_instr <= w_skid_instr;
    end else if (w_bubble) begin
      r_if_id_valid <= 1'b0;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_take_skid),
    .i_clear (w_skid_clear),
    .i_pc    (r_pc),
    .i_instr (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  // Decode-facing outputs; an empty IF/ID presents the NOP opcode.
  always_comb begin
    if_id_valid = r_if_id_valid;
    if_id_pc    = r_if_id_pc;
    if_id_instr = r_if_id_instr;
    operation   = r_if_id_valid ? opcode_of(r_if_id_instr) : NOP_OPCODE;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: reset, zero-wait fetch, wait states,
// stall/skid release, branch redirect and flush, PC wrap, reset during FULL.
module tb_instruction_fetch;
  import legv8_pkg::*;

  localparam int ADDR_W = 64;

  logic               clk;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ready;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               if_id_valid;
  logic [ADDR_W-1:0]  if_id_pc;
  logic [31:0]        if_id_instr;
  logic [10:0]        operation;
  fetch_state_e       dbg_state;

  int n_cmp;
  int n_fail;

  localparam logic [31:0] W_DEF = 32'hDEADBEEF;

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .operation     (operation),
    .dbg_state     (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    case (a)
      64'h0:   return 32'hF84003E1;
      64'h4:   return 32'h8B020020;
      64'h8:   return 32'hD2800041;
      64'hC:   return 32'hCB030041;
      default: return W_DEF;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    step(); step();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
    n_cmp++; if (if_id_pc !== 64'h0) begin n_fail++; $display("FAIL rst_ifid_pc got %h exp 0", if_id_pc); end
    n_cmp++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", if_id_instr); end
    n_cmp++; if (operation !== 11'b0) begin n_fail++; $display("FAIL rst_op got %b exp 0", operation); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp IDLE", dbg_state); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (dbg_state !== FETCH) begin n_fail++; $display("FAIL rel_state got %0d exp FETCH", dbg_state); end
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got %b exp 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    imem_ready = 1'b1;
    step();
    n_cmp++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL zw0_valid got %b exp 1", if_id_valid); end
    n_cmp++; if (if_id_pc !== 64'h0) begin n_fail++; $display("FAIL zw0_pc got %h exp 0", if_id_pc); end
    n_cmp++; if (if_id_instr !== 32'hF84003E1) begin n_fail++; $display("FAIL zw0_instr got %h exp f84003e1", if_id_instr); end
    n_cmp++; if (operation !== 11'b11111000010) begin n_fail++; $display("FAIL zw0_op got %b exp 11111000010", operation); end
    n_cmp++; if (imem_addr !== 64'h4) begin n_fail++; $display("FAIL zw0_addr got %h exp 4", imem_addr); end
    step();
    n_cmp++; if (if_id_pc !== 64'h4) begin n_fail++; $display("FAIL zw1_pc got %h exp 4", if_id_pc); end
    n_cmp++; if (operation !== 11'b10001011000) begin n_fail++; $display("FAIL zw1_op got %b exp 10001011000", operation); end
    n_cmp++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL zw1_addr got %h exp 8", imem_addr); end
  endtask

  task automatic test_stall();
    // Word at 0x8 returns while decode is stalled.
    imem_ready = 1'b1; stall = 1'b1;
    step();
    n_cmp++; if (dbg_state !== FULL) begin n_fail++; $display("FAIL st0_state got %0d exp FULL", dbg_state); end
    n_cmp++; if (if_id_pc !== 64'h4 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st0_ifid got pc %h v %b exp pc 4 v 1", if_id_pc, if_id_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st0_req got %b exp 0", imem_req); end
    imem_ready = 1'b0;
    step();
    n_cmp++; if (dbg_state !== FULL) begin n_fail++; $display("FAIL st1_state got %0d exp FULL", dbg_state); end
    n_cmp++; if (if_id_pc !== 64'h4 || if_id_instr !== 32'h8B020020) begin n_fail++; $display("FAIL st1_ifid got pc %h i %h exp pc 4 i 8b020020", if_id_pc, if_id_instr); end
    stall = 1'b0;
    step();
    n_cmp++; if (if_id_pc !== 64'h8 || if_id_instr !== 32'hD2800041 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st2_ifid got pc %h i %h v %b exp pc 8 i d2800041 v 1", if_id_pc, if_id_instr, if_id_valid); end
    n_cmp++; if (dbg_state !== FETCH) begin n_fail++; $display("FAIL st2_state got %0d exp FETCH", dbg_state); end
    n_cmp++; if (imem_addr !== 64'hC || imem_req !== 1'b1) begin n_fail++; $display("FAIL st2_req got addr %h req %b exp addr c req 1", imem_addr, imem_req); end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (imem_addr !== 64'hC || imem_req !== 1'b1) begin n_fail++; $display("FAIL ws%0d_addr got %h req %b exp c 1", i, imem_addr, imem_req); end
      n_cmp++; if (if_id_valid !== 1'b0 || operation !== 11'b0) begin n_fail++; $display("FAIL ws%0d_bubble got v %b op %b exp 0 0", i, if_id_valid, operation); end
    end
    imem_ready = 1'b1;
    step();
    n_cmp++; if (if_id_pc !== 64'hC || if_id_instr !== 32'hCB030041 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ws_done got pc %h i %h v %b exp c cb030041 1", if_id_pc, if_id_instr, if_id_valid); end
    n_cmp++; if (imem_addr !== 64'h10) begin n_fail++; $display("FAIL ws_next got %h exp 10", imem_addr); end
  endtask

  task automatic test_branch();
    // Fill the skid buffer, then redirect while in FULL.
    imem_ready = 1'b1; stall = 1'b1;
    step();
    n_cmp++; if (dbg_state !== FULL) begin n_fail++; $display("FAIL br0_state got %0d exp FULL", dbg_state); end
    branch_taken = 1'b1; branch_target = 64'h100; imem_ready = 1'b0;
    step();
    n_cmp++; if (dbg_state !== FETCH) begin n_fail++; $display("FAIL br1_state got %0d exp FETCH", dbg_state); end
    n_cmp++; if (if_id_valid !== 1'b0 || operation !== 11'b0) begin n_fail++; $display("FAIL br1_flush got v %b op %b exp 0 0", if_id_valid, operation); end
    n_cmp++; if (imem_addr !== 64'h100) begin n_fail++; $display("FAIL br1_addr got %h exp 100", imem_addr); end
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    step();
    n_cmp++; if (if_id_pc !== 64'h100 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br2_ifid got pc %h v %b exp 100 1", if_id_pc, if_id_valid); end
    // Redirect to a misaligned target while a response arrives under stall.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
    step();
    n_cmp++; if (imem_addr !== 64'h100) begin n_fail++; $display("FAIL br3_align got %h exp 100", imem_addr); end
    n_cmp++; if (dbg_state !== FETCH || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br3_state got %0d v %b exp FETCH 0", dbg_state, if_id_valid); end
    branch_taken = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (if_id_pc !== 64'h100 || if_id_instr !== W_DEF) begin n_fail++; $display("FAIL br4_ifid got pc %h i %h exp 100 deadbeef", if_id_pc, if_id_instr); end
    n_cmp++; if (imem_addr !== 64'h104) begin n_fail++; $display("FAIL br4_addr got %h exp 104", imem_addr); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wr0_addr got %h exp fffffffffffffffc", imem_addr); end
    branch_taken = 1'b0;
    step();
    n_cmp++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wr1_pc got %h exp fffffffffffffffc", if_id_pc); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL wr1_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_reset_mid_full();
    stall = 1'b1; imem_ready = 1'b1;
    step();
    n_cmp++; if (dbg_state !== FULL) begin n_fail++; $display("FAIL rm0_state got %0d exp FULL", dbg_state); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== 32'h0 || operation !== 11'b0) begin n_fail++; $display("FAIL rm1_ifid got v %b pc %h i %h op %b exp all 0", if_id_valid, if_id_pc, if_id_instr, operation); end
    n_cmp++; if (imem_req !== 1'b0 || dbg_state !== IDLE || imem_addr !== 64'h0) begin n_fail++; $display("FAIL rm1_fsm got req %b st %0d addr %h exp 0 IDLE 0", imem_req, dbg_state, imem_addr); end
    stall = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rm2_state got %0d exp IDLE", dbg_state); end
    step();
    n_cmp++; if (dbg_state !== FETCH || imem_addr !== 64'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rm3_restart got st %0d addr %h req %b exp FETCH 0 1", dbg_state, imem_addr, imem_req); end
    step();
    n_cmp++; if (if_id_pc !== 64'h0 || if_id_instr !== 32'hF84003E1 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rm4_ifid got pc %h i %h v %b exp 0 f84003e1 1", if_id_pc, if_id_instr, if_id_valid); end
  endtask

  // Watchdog: bench is purely step-driven, but never allow a hang.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_wait_states();
    test_branch();
    test_wrap();
    test_reset_mid_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage and IF/ID pipeline register for the LEGv8 datapath. Holds the PC, issues word reads to instruction memory over a request/ready handshake, and presents the fetched instruction plus its 11-bit opcode field to the control unit in decode. Supports decode-stage stalls with a one-entry skid buffer and branch redirects with IF/ID flush.

## Interface
Parameters:
- ADDR_W, 64, PC / instruction address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  word address of fetch (equals pc)
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory response for current request
- stall  in  1  decode hazard stall; freeze IF/ID
- branch_taken  in  1  redirect request (Branch & Zero, resolved downstream)
- branch_target  in  ADDR_W  redirect address
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  ADDR_W  PC of instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID
- operation  out  11  if_id_instr[31:21] when if_id_valid, else 11'b0

## Operation
- States: IDLE, FETCH, FULL.
- IDLE: entered on reset; imem_req=0; always -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & !stall: IF/ID <= {1, pc, rdata}; pc <= pc+4; stay FETCH.
  - ready & stall: skid buffer <= {pc, rdata}; pc <= pc+4; -> FULL.
  - !ready & !stall: if_id_valid <= 0 (bubble); hold pc.
  - !ready & stall: IF/ID held; hold pc.
- FULL: imem_req=0; IF/ID held while stall.
  - !stall: IF/ID <= buffer, valid=1; buffer cleared; -> FETCH.
- branch_taken (any state, highest priority): pc <= {branch_target[ADDR_W-1:2], 2'b00}; if_id_valid <= 0; buffer cleared; response in that cycle discarded; -> FETCH. Overrides stall.
- pc+4 wraps modulo 2^ADDR_W.
- operation = 11'b0 when invalid, so control unit decodes a NOP (all controls 0).
- imem_addr stable while imem_req=1 and imem_ready=0 (unless branch_taken).

## Timing
- Reset (async assert): state=IDLE, pc=RESET_PC, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=0, operation=0, buffer empty. Deassert: IDLE for one cycle, first request next cycle.
- Zero-wait memory (ready same cycle as req): instruction appears at IF/ID outputs one cycle after request; throughput one instruction per cycle.
- Stall latency: instruction returned during stall is released into IF/ID on the edge after stall drops; no instruction lost or duplicated.
- Branch: redirected address on imem_addr the cycle after branch_taken; IF/ID shows bubble that cycle.
- Reset mid-request: outstanding response ignored; fetch restarts at RESET_PC.

## Structure
- Shared package legv8_pkg: INSTR_W=32, OPCODE_W=11, OPCODE_MSB=31/LSB=21, NOP_OPCODE=11'b0, fetch state enum {IDLE, FETCH, FULL}.
- One sub-module: fetch_skid_buffer (one-entry {pc, instr} holding register with load/clear/valid).

## Test plan
- Reset, zero-wait memory returning 0xF84003E1 at 0x0, 0x8B020020 at 0x4 -> if_id_pc 0x0 then 0x4 on consecutive cycles; operation 11'b11111000010 then 11'b10001011000.
- Memory ready delayed 3 cycles -> imem_addr held 3 cycles, if_id_valid=0 meanwhile, operation=0.
- stall high 2 cycles while ready returns word at 0x8 -> state FULL, IF/ID unchanged, word at 0x8 enters IF/ID the cycle after stall drops, next request at 0xC.
- branch_taken with target 0x100 during stall and FULL -> buffer dropped, if_id_valid=0, next imem_addr=0x100.
- branch_target 0x103 -> imem_addr 0x100; pc at 0xFFFF_FFFF_FFFF_FFFC +4 -> 0x0.
- rst_n asserted mid-FULL -> all outputs 0 immediately, restart at RESET_PC after IDLE cycle.
